// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake, flush/busy and shared-ALU signals of the multiply sequencer.
// master = surrounding datapath (requester, consumer, ALU); slave = the sequencer.
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             flush;
  logic             busy;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output req_valid, req_a, req_b, resp_ready, flush, alu_result,
    input  req_ready, resp_valid, resp_data, busy, alu_op, alu_a, alu_b
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, flush, alu_result,
    output req_ready, resp_valid, resp_data, busy, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 -> low-32 multiplier that borrows the shared single-cycle ALU
// for every add and shift; ALU controls depend on internal state only.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_mul_sequencer_if.slave   bus
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_ZERO = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             added_q, added_d;
  logic             add_step;

  // An add step is pending when the current multiplier LSB is set and not yet consumed.
  assign add_step = mplier_q[0] && !added_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      resp_data_q <= '0;
      added_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      resp_data_q <= resp_data_d;
      added_q     <= added_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    resp_data_d = resp_data_q;
    added_d     = added_q;
    if (bus.flush) begin
      state_d = S_IDLE;
      added_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            mcand_d  = bus.req_a;
            mplier_d = bus.req_b;
            acc_d    = '0;
            added_d  = 1'b0;
            state_d  = S_RUN;
          end
        end
        S_RUN: begin
          if (mplier_q == '0) begin
            resp_data_d = acc_q;
            state_d     = S_DONE;
          end else if (add_step) begin
            acc_d   = bus.alu_result;
            added_d = 1'b1;
          end else begin
            mcand_d  = bus.alu_result;
            mplier_d = mplier_q >> 1;
            added_d  = 1'b0;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.resp_valid = (state_q == S_DONE);
    bus.busy       = (state_q == S_RUN) || (state_q == S_DONE);
    bus.resp_data  = resp_data_q;
    bus.alu_op     = OP_ZERO;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    if (state_q == S_RUN && mplier_q != '0) begin
      if (add_step) begin
        bus.alu_op = OP_ADD;
        bus.alu_a  = acc_q;
        bus.alu_b  = mcand_q;
      end else begin
        bus.alu_op = OP_SLL;
        bus.alu_a  = mcand_q;
        bus.alu_b  = WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: vector table with hand-computed products and
// latencies, plus back-pressure, flush and reset sequences. Includes a reference ALU.
module tb_alu_mul_sequencer;
  logic clk = 1'b0;
  logic reset;

  alu_mul_sequencer_if #(.WIDTH(32)) bus ();

  alu_mul_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU as seen by the sequencer.
  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b100:  bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      default: bus.alu_result = '0;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          adds;
    int          shifts;
  } vec_t;

  vec_t       vecs[9];
  logic [2:0] trace[$];
  int         total = 0;
  int         bad   = 0;
  int         nbusy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request during the current (IDLE) cycle; returns #1 after the accept edge.
  task automatic start_req(input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Accept, then count cycles (accept cycle + 1 = 1) until resp_valid, tracing ALU ops.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, output int cyc);
    start_req(a, b);
    cyc = 1;
    nbusy = 0;
    trace.delete();
    while (!bus.resp_valid && cyc < 100) begin
      trace.push_back(bus.alu_op);
      if (!bus.busy || bus.req_ready) nbusy++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic release_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  function automatic int count_op(input logic [2:0] op);
    int n = 0;
    foreach (trace[i]) if (trace[i] == op) n++;
    return n;
  endfunction

  initial begin
    int          cyc;
    logic [31:0] held;
    logic [2:0]  seq76[6];
    int          seen;

    vecs[0] = '{32'd7,        32'd6,        32'd42,       7,  2,  3};
    vecs[1] = '{32'h1234,     32'd0,        32'd0,        2,  0,  0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 66, 32, 32};
    vecs[3] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 7,  2,  3};
    vecs[4] = '{32'd3,        32'd3,        32'd9,        6,  2,  2};
    vecs[5] = '{32'd0,        32'h80000000, 32'd0,        35, 1,  32};
    vecs[6] = '{32'h10,       32'hFF,       32'hFF0,      18, 8,  8};
    vecs[7] = '{32'h10000,    32'h10000,    32'd0,        20, 1,  17};
    vecs[8] = '{32'hFFFF,     32'h10001,    32'hFFFFFFFF, 21, 2,  17};
    seq76   = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b110};

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
    bus.resp_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_alu_op", {29'd0, bus.alu_op}, 32'd6);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // flush wins over a simultaneous request in IDLE
    bus.flush = 1'b1;
    start_req(32'd5, 32'd5);
    bus.flush = 1'b0;
    check("flush_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    check("flush_idle_busy", {31'd0, bus.busy}, 32'd0);

    for (int unsigned v = 0; v < 9; v++) begin
      do_req(vecs[v].a, vecs[v].b, cyc);
      check($sformatf("v%0d_latency", v), cyc, vecs[v].lat);
      check($sformatf("v%0d_data", v), bus.resp_data, vecs[v].exp);
      check($sformatf("v%0d_adds", v), count_op(3'b000), vecs[v].adds);
      check($sformatf("v%0d_shifts", v), count_op(3'b100), vecs[v].shifts);
      check($sformatf("v%0d_busy", v), nbusy + (bus.busy ? 0 : 1), 32'd0);
      if (v == 0) begin
        check("v0_trace_len", trace.size(), 32'd6);
        for (int i = 0; i < 6 && i < trace.size(); i++)
          check($sformatf("v0_op%0d", i), {29'd0, trace[i]}, {29'd0, seq76[i]});
      end
      release_resp();
      check($sformatf("v%0d_idle_after", v), {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
    end

    // back-pressure then back-to-back request
    do_req(32'd7, 32'd6, cyc);
    check("bp_latency", cyc, 32'd7);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("bp_data", bus.resp_data, 32'd42);
      check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    release_resp();
    check("bp_idle", {31'd0, bus.req_ready}, 32'd1);
    do_req(32'd3, 32'd3, cyc);
    check("b2b_latency", cyc, 32'd6);
    check("b2b_data", bus.resp_data, 32'd9);
    release_resp();

    // flush in RUN cycle 3
    held = bus.resp_data;
    start_req(32'h10, 32'hFF);
    repeat (2) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_ready", {31'd0, bus.req_ready}, 32'd1);
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.resp_valid || bus.resp_data !== held) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_resp", seen, 32'd0);
    check("flush_data_kept", bus.resp_data, 32'd9);
    do_req(32'd2, 32'd2, cyc);
    check("flush_next_lat", cyc, 32'd5);
    check("flush_next_data", bus.resp_data, 32'd4);
    release_resp();

    // reset in RUN cycle 3
    start_req(32'h10, 32'hFF);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rrun_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rrun_busy", {31'd0, bus.busy}, 32'd0);
    check("rrun_data", bus.resp_data, 32'd0);
    check("rrun_alu_op", {29'd0, bus.alu_op}, 32'd6);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.resp_valid || bus.resp_data !== 32'd0) seen++;
      @(posedge clk); #1;
    end
    check("rrun_no_resp", seen, 32'd0);
    do_req(32'd2, 32'd2, cyc);
    check("rrun_next_lat", cyc, 32'd5);
    check("rrun_next_data", bus.resp_data, 32'd4);
    release_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
